// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_pkg
//  Description : Shared constants and grant helper for the CDB arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef RoB_addr
`define RoB_addr 4
`endif

package cdb_arbiter_pkg;

    // Default ROB index width, taken from the global ROB address macro.
    localparam int ROB_ADDR_W = `RoB_addr;

    // Source encoding on cdb_src and in the last-grant register.
    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_LSB = 1'b1;

    // Round-robin pick between two requesters. Returns {grant_lsb, grant_alu}.
    // On a tie the source that did not win last time is chosen.
    function automatic logic [1:0] rr_grant(input logic req_alu,
                                            input logic req_lsb,
                                            input logic last_grant);
        logic [1:0] g;
        g = 2'b00;
        if (req_alu && req_lsb) begin
            if (last_grant == CDB_SRC_ALU) g = 2'b10;
            else                           g = 2'b01;
        end else begin
            g = {req_lsb, req_alu};
        end
        return g;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_fifo
//  Description : Small circular result buffer with push/pop/clear and an
//                always-visible head entry. DEPTH must be a power of two >= 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       en_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Next pointer/count values; pointers wrap naturally since DEPTH is 2^n.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers, frozen while en_i is low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (en_i) begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_in) begin
        if (en_i && push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Merges ALU and LSB results onto one registered CDB broadcast.
//                Each source has a result FIFO with empty-FIFO bypass; a
//                round-robin grant picks at most one result per cycle, and
//                stall outputs throttle the producers one entry before full.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ROB_W = ROB_ADDR_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    input  logic             alu_valid,
    input  logic [ROB_W-1:0] alu_robid,
    input  logic [31:0]      alu_val,
    input  logic             lsb_valid,
    input  logic [ROB_W-1:0] lsb_robid,
    input  logic [31:0]      lsb_val,
    output logic             alu_stall,
    output logic             lsb_stall,
    output logic             cdb_valid,
    output logic [ROB_W-1:0] cdb_robid,
    output logic [31:0]      cdb_val,
    output logic             cdb_src,
    output logic             err_overflow
);

    localparam int ENTRY_W = ROB_W + 32;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] C_STALL_LVL = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_FULL_LVL  = CNT_W'(DEPTH);

    // FIFO interface
    logic [ENTRY_W-1:0] w_alu_head, w_lsb_head;
    logic [CNT_W-1:0]   w_alu_count, w_lsb_count;
    logic               w_alu_push, w_lsb_push;
    logic               w_alu_pop,  w_lsb_pop;

    // Candidate / grant
    logic               w_alu_empty, w_lsb_empty;
    logic               w_alu_cand, w_lsb_cand;
    logic [ENTRY_W-1:0] w_alu_cand_data, w_lsb_cand_data;
    logic               w_gnt_alu, w_gnt_lsb;
    logic               w_alu_drop, w_lsb_drop;
    logic [1:0]         w_gnt;

    // Registered state
    logic               cdb_valid_q, cdb_valid_d;
    logic [ROB_W-1:0]   cdb_robid_q, cdb_robid_d;
    logic [31:0]        cdb_val_q,   cdb_val_d;
    logic               cdb_src_q,   cdb_src_d;
    logic               err_q,       err_d;
    logic               last_grant_q, last_grant_d;

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_alu_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .en_i        (rdy_in),
        .clear_i     (flush),
        .push_i      (w_alu_push),
        .push_data_i ({alu_robid, alu_val}),
        .pop_i       (w_alu_pop),
        .head_o      (w_alu_head),
        .count_o     (w_alu_count)
    );

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_lsb_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .en_i        (rdy_in),
        .clear_i     (flush),
        .push_i      (w_lsb_push),
        .push_data_i ({lsb_robid, lsb_val}),
        .pop_i       (w_lsb_pop),
        .head_o      (w_lsb_head),
        .count_o     (w_lsb_count)
    );

    // Candidate selection, round-robin grant and FIFO push/pop decisions.
    always_comb begin
        w_alu_empty     = (w_alu_count == '0);
        w_lsb_empty     = (w_lsb_count == '0);
        w_alu_cand      = !w_alu_empty || alu_valid;
        w_lsb_cand      = !w_lsb_empty || lsb_valid;
        w_alu_cand_data = w_alu_empty ? {alu_robid, alu_val} : w_alu_head;
        w_lsb_cand_data = w_lsb_empty ? {lsb_robid, lsb_val} : w_lsb_head;

        // A flush suppresses every grant in its cycle.
        w_gnt     = flush ? 2'b00 : rr_grant(w_alu_cand, w_lsb_cand, last_grant_q);
        w_gnt_alu = w_gnt[0];
        w_gnt_lsb = w_gnt[1];

        // A granted non-empty FIFO gives up its head; an empty one was bypassed.
        w_alu_pop = w_gnt_alu && !w_alu_empty;
        w_lsb_pop = w_gnt_lsb && !w_lsb_empty;

        // Full FIFO can still accept when its head leaves in the same cycle.
        w_alu_drop = !flush && alu_valid && !(w_gnt_alu && w_alu_empty)
                     && (w_alu_count == C_FULL_LVL) && !w_alu_pop;
        w_lsb_drop = !flush && lsb_valid && !(w_gnt_lsb && w_lsb_empty)
                     && (w_lsb_count == C_FULL_LVL) && !w_lsb_pop;

        w_alu_push = !flush && alu_valid && !(w_gnt_alu && w_alu_empty) && !w_alu_drop;
        w_lsb_push = !flush && lsb_valid && !(w_gnt_lsb && w_lsb_empty) && !w_lsb_drop;
    end

    // Next values of the broadcast registers, last-grant and sticky error.
    always_comb begin
        cdb_valid_d  = w_gnt_alu || w_gnt_lsb;
        cdb_robid_d  = cdb_robid_q;
        cdb_val_d    = cdb_val_q;
        cdb_src_d    = cdb_src_q;
        last_grant_d = last_grant_q;
        err_d        = err_q || w_alu_drop || w_lsb_drop;
        if (w_gnt_alu) begin
            {cdb_robid_d, cdb_val_d} = w_alu_cand_data;
            cdb_src_d    = CDB_SRC_ALU;
            last_grant_d = CDB_SRC_ALU;
        end else if (w_gnt_lsb) begin
            {cdb_robid_d, cdb_val_d} = w_lsb_cand_data;
            cdb_src_d    = CDB_SRC_LSB;
            last_grant_d = CDB_SRC_LSB;
        end
        if (flush) begin
            last_grant_d = CDB_SRC_LSB;
        end
    end

    // Broadcast and control registers; everything holds while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cdb_valid_q  <= 1'b0;
            cdb_robid_q  <= '0;
            cdb_val_q    <= '0;
            cdb_src_q    <= CDB_SRC_ALU;
            err_q        <= 1'b0;
            last_grant_q <= CDB_SRC_LSB;
        end else if (rdy_in) begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_robid_q  <= cdb_robid_d;
            cdb_val_q    <= cdb_val_d;
            cdb_src_q    <= cdb_src_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Stall one entry early to absorb the producer's in-flight result.
    assign alu_stall    = (w_alu_count >= C_STALL_LVL);
    assign lsb_stall    = (w_lsb_count >= C_STALL_LVL);

    assign cdb_valid    = cdb_valid_q;
    assign cdb_robid    = cdb_robid_q;
    assign cdb_val      = cdb_val_q;
    assign cdb_src      = cdb_src_q;
    assign err_overflow = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Directed self-checking bench for cdb_arbiter (DEPTH = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic        alu_valid;
    logic [3:0]  alu_robid;
    logic [31:0] alu_val;
    logic        lsb_valid;
    logic [3:0]  lsb_robid;
    logic [31:0] lsb_val;
    logic        alu_stall, lsb_stall;
    logic        cdb_valid;
    logic [3:0]  cdb_robid;
    logic [31:0] cdb_val;
    logic        cdb_src;
    logic        err_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_arbiter #(.DEPTH(4), .ROB_W(4)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush        (flush),
        .alu_valid    (alu_valid),
        .alu_robid    (alu_robid),
        .alu_val      (alu_val),
        .lsb_valid    (lsb_valid),
        .lsb_robid    (lsb_robid),
        .lsb_val      (lsb_val),
        .alu_stall    (alu_stall),
        .lsb_stall    (lsb_stall),
        .cdb_valid    (cdb_valid),
        .cdb_robid    (cdb_robid),
        .cdb_val      (cdb_val),
        .cdb_src      (cdb_src),
        .err_overflow (err_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_in(input logic av, input logic [3:0] ar, input logic [31:0] ad,
                          input logic lv, input logic [3:0] lr, input logic [31:0] ld);
        alu_valid = av; alu_robid = ar; alu_val = ad;
        lsb_valid = lv; lsb_robid = lr; lsb_val = ld;
    endtask

    task automatic clr_in();
        set_in(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
        clr_in();
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    // Contention source pattern for cycle i: ALU robid i / 0x100+i, LSB robid 8+i / 0x200+i.
    task automatic drive_both(input int i);
        set_in(1'b1, 4'(i), 32'h100 + 32'(i), 1'b1, 4'(8 + i), 32'h200 + 32'(i));
    endtask

    // Expected j-th broadcast of the contention stream: strict alternation, ALU first.
    task automatic chk_stream(input int j);
        logic [3:0]  er;
        logic [31:0] ev;
        if (j % 2 == 0) begin
            er = 4'(j / 2);
            ev = 32'h100 + 32'(j / 2);
        end else begin
            er = 4'(8 + (j - 1) / 2);
            ev = 32'h200 + 32'((j - 1) / 2);
        end
        chk($sformatf("stream%0d_valid", j), 64'(cdb_valid), 64'd1);
        chk($sformatf("stream%0d_src", j),   64'(cdb_src),   64'(j % 2));
        chk($sformatf("stream%0d_robid", j), 64'(cdb_robid), 64'(er));
        chk($sformatf("stream%0d_val", j),   64'(cdb_val),   64'(ev));
    endtask

    initial begin
        do_reset();
        #1;

        // Reset state
        chk("rst_valid", 64'(cdb_valid),    64'd0);
        chk("rst_robid", 64'(cdb_robid),    64'd0);
        chk("rst_val",   64'(cdb_val),      64'd0);
        chk("rst_src",   64'(cdb_src),      64'd0);
        chk("rst_err",   64'(err_overflow), 64'd0);
        chk("rst_astl",  64'(alu_stall),    64'd0);
        chk("rst_lstl",  64'(lsb_stall),    64'd0);

        // Single ALU result bypassed onto the CDB
        set_in(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'd0);
        tick();
        clr_in();
        chk("single_valid", 64'(cdb_valid), 64'd1);
        chk("single_robid", 64'(cdb_robid), 64'd3);
        chk("single_val",   64'(cdb_val),   64'h11);
        chk("single_src",   64'(cdb_src),   64'd0);
        tick();
        chk("single_pulse", 64'(cdb_valid), 64'd0);
        chk("single_hold",  64'(cdb_robid), 64'd3);

        // Tie after reset: ALU wins first, LSB follows
        do_reset();
        set_in(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hB2);
        tick();
        clr_in();
        chk("tie0_robid", 64'(cdb_robid), 64'd1);
        chk("tie0_src",   64'(cdb_src),   64'd0);
        tick();
        chk("tie1_valid", 64'(cdb_valid), 64'd1);
        chk("tie1_robid", 64'(cdb_robid), 64'd2);
        chk("tie1_val",   64'(cdb_val),   64'hB2);
        chk("tie1_src",   64'(cdb_src),   64'd1);
        tick();
        chk("tie_idle",   64'(cdb_valid), 64'd0);

        // Contention: 6 cycles of both sources, then drain; nothing lost
        do_reset();
        for (int j = 0; j < 12; j++) begin
            if (j < 6) drive_both(j);
            else       clr_in();
            tick();
            chk_stream(j);
            if (j == 4) begin
                chk("cont_astl4", 64'(alu_stall), 64'd0);
                chk("cont_lstl4", 64'(lsb_stall), 64'd1);
            end
            if (j == 5) chk("cont_astl5", 64'(alu_stall), 64'd1);
        end
        clr_in();
        tick();
        chk("cont_done_valid", 64'(cdb_valid), 64'd0);
        chk("cont_done_astl",  64'(alu_stall), 64'd0);
        chk("cont_done_lstl",  64'(lsb_stall), 64'd0);
        chk("cont_err",        64'(err_overflow), 64'd0);

        // Overflow: both FIFOs reach 4 after cycle 7; first drop in cycle 8
        do_reset();
        for (int k = 0; k < 12; k++) begin
            drive_both(k % 8);
            tick();
            if (k == 7) begin
                chk("ovf_pre",  64'(err_overflow), 64'd0);
                chk("ovf_lstl", 64'(lsb_stall),    64'd1);
            end
            if (k >= 8) chk($sformatf("ovf_set%0d", k), 64'(err_overflow), 64'd1);
        end
        clr_in();
        for (int k = 0; k < 10; k++) tick();
        chk("ovf_sticky", 64'(err_overflow), 64'd1);

        // Flush with 3 entries queued per source and inputs valid
        do_reset();
        for (int j = 0; j < 6; j++) begin
            drive_both(j);
            tick();
        end
        chk("fl_pre_astl", 64'(alu_stall), 64'd1);
        set_in(1'b1, 4'd7, 32'h777, 1'b1, 4'd15, 32'hFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clr_in();
        chk("fl_valid", 64'(cdb_valid), 64'd0);
        chk("fl_astl",  64'(alu_stall), 64'd0);
        chk("fl_lstl",  64'(lsb_stall), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fl_quiet%0d", k), 64'(cdb_valid), 64'd0);
        end
        set_in(1'b1, 4'd5, 32'h55, 1'b1, 4'd6, 32'h66);
        tick();
        clr_in();
        chk("fl_rr_robid", 64'(cdb_robid), 64'd5);
        chk("fl_rr_src",   64'(cdb_src),   64'd0);
        tick();
        chk("fl_rr2_robid", 64'(cdb_robid), 64'd6);
        chk("fl_err",       64'(err_overflow), 64'd0);

        // Freeze: rdy_in low for 3 cycles with queued entries and live inputs
        do_reset();
        for (int j = 0; j < 6; j++) begin
            drive_both(j);
            tick();
        end
        rdy_in = 1'b0;
        set_in(1'b1, 4'd7, 32'h777, 1'b1, 4'd15, 32'hFFF);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("frz%0d_valid", k), 64'(cdb_valid), 64'd1);
            chk($sformatf("frz%0d_robid", k), 64'(cdb_robid), 64'd10);
            chk($sformatf("frz%0d_val", k),   64'(cdb_val),   64'h202);
            chk($sformatf("frz%0d_src", k),   64'(cdb_src),   64'd1);
            chk($sformatf("frz%0d_astl", k),  64'(alu_stall), 64'd1);
            chk($sformatf("frz%0d_lstl", k),  64'(lsb_stall), 64'd1);
        end
        rdy_in = 1'b1;
        clr_in();
        for (int j = 6; j < 12; j++) begin
            tick();
            chk_stream(j);
        end
        tick();
        chk("frz_done_valid", 64'(cdb_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
